// File: rtl/uart_tx_if.sv
// Shared UART types plus the ready/valid byte channel used on the transmit port.
package uart_tx_pkg;

  typedef enum int unsigned {
    BR_9600   = 9600,
    BR_19200  = 19200,
    BR_38400  = 38400,
    BR_57600  = 57600,
    BR_115200 = 115200,
    BR_230400 = 230400,
    BR_460800 = 460800,
    BR_921600 = 921600
  } uart_baud_rate_t;

  function automatic bit is_pow2(input int unsigned v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

interface rv_if #(
  parameter int unsigned DW = 8
);
  logic          valid;
  logic          ready;
  logic [DW-1:0] data;

  modport master (output valid, output data, input  ready);
  modport slave  (input  valid, input  data, output ready);
  modport TX     (output valid, output data, input  ready);
  modport RX     (input  valid, input  data, output ready);
endinterface

// File: rtl/uart_tx.sv
// 8N1 UART transmitter, LSB first: a small byte FIFO feeding a registered-output
// start/data/stop serialiser.
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int unsigned     CLOCK_FREQ = 100_000_000,
  parameter uart_baud_rate_t BAUD_RATE  = BR_115200,
  parameter int unsigned     FIFO_DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  rv_if.RX     send,
  output logic serial_out,
  output logic tx_ready,
  output logic tx_busy
);

  localparam int unsigned CLKS_PER_BIT = CLOCK_FREQ / int'(BAUD_RATE);
  localparam int unsigned CPB_SAFE     = (CLKS_PER_BIT == 0) ? 1 : CLKS_PER_BIT;
  localparam int unsigned CW           = (CPB_SAFE > 2) ? $clog2(CPB_SAFE) : 1;
  localparam int unsigned AW           = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned PW           = AW + 1;

  localparam longint unsigned BAUD_NOM = longint'(int'(BAUD_RATE));
  localparam longint unsigned BAUD_ACT = longint'(CLOCK_FREQ / CPB_SAFE);
  localparam longint unsigned BAUD_ERR = (BAUD_ACT > BAUD_NOM) ? (BAUD_ACT - BAUD_NOM)
                                                               : (BAUD_NOM - BAUD_ACT);

  if (CLKS_PER_BIT < 2) begin : g_chk_cpb
    $fatal(1, "uart_tx: CLKS_PER_BIT must be at least 2");
  end
  if (!is_pow2(FIFO_DEPTH) || FIFO_DEPTH < 2) begin : g_chk_depth
    $fatal(1, "uart_tx: FIFO_DEPTH must be a power of two and at least 2");
  end
  if (BAUD_ERR * 50 > BAUD_NOM) begin : g_chk_baud
    $fatal(1, "uart_tx: baud rate error exceeds 2 percent");
  end

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  // FIFO: extra pointer MSB separates full from empty when the indices meet
  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic [7:0]    head;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push  = send.valid && !full;
  assign head  = mem[rd_ptr[AW-1:0]];

  assign send.ready = !full;
  assign tx_ready   = !full;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= send.data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Serialiser
  state_t        state, state_n;
  logic [CW-1:0] baud_cnt, baud_cnt_n;
  logic [2:0]    bit_cnt, bit_cnt_n;
  logic [7:0]    shift, shift_n;
  logic          serial_n;
  logic          baud_last;

  assign baud_last = (baud_cnt == CW'(CLKS_PER_BIT - 1));
  assign tx_busy   = (state != IDLE) || !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      serial_out <= 1'b1;
    end else begin
      state      <= state_n;
      baud_cnt   <= baud_cnt_n;
      bit_cnt    <= bit_cnt_n;
      shift      <= shift_n;
      serial_out <= serial_n;
    end
  end

  always_comb begin
    state_n    = state;
    baud_cnt_n = baud_cnt;
    bit_cnt_n  = bit_cnt;
    shift_n    = shift;
    serial_n   = serial_out;
    pop        = 1'b0;

    case (state)
      IDLE: begin
        serial_n   = 1'b1;
        baud_cnt_n = '0;
        if (!empty) begin
          pop      = 1'b1;
          shift_n  = head;
          state_n  = START;
          serial_n = 1'b0;
        end
      end

      START: begin
        if (baud_last) begin
          state_n    = DATA;
          baud_cnt_n = '0;
          bit_cnt_n  = '0;
          serial_n   = shift[0];
        end else begin
          baud_cnt_n = baud_cnt + CW'(1);
        end
      end

      // The line is registered, so the next bit is taken from shift[1] as the shift happens
      DATA: begin
        if (baud_last) begin
          baud_cnt_n = '0;
          if (bit_cnt == 3'd7) begin
            state_n  = STOP;
            serial_n = 1'b1;
          end else begin
            bit_cnt_n = bit_cnt + 3'd1;
            shift_n   = {1'b0, shift[7:1]};
            serial_n  = shift[1];
          end
        end else begin
          baud_cnt_n = baud_cnt + CW'(1);
        end
      end

      STOP: begin
        if (baud_last) begin
          baud_cnt_n = '0;
          if (!empty) begin
            pop      = 1'b1;
            shift_n  = head;
            state_n  = START;
            serial_n = 1'b0;
          end else begin
            state_n  = IDLE;
            serial_n = 1'b1;
          end
        end else begin
          baud_cnt_n = baud_cnt + CW'(1);
        end
      end

      default: begin
        state_n  = IDLE;
        serial_n = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at CLKS_PER_BIT=8 (80-cycle frames).
module tb_uart_tx;

  localparam int unsigned CLK_HZ = 921_600;
  localparam int unsigned DEPTH  = 4;
  localparam int          FRAME  = 80;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rv_if #(.DW(8)) send_if ();
  logic serial_out;
  logic tx_ready;
  logic tx_busy;

  uart_tx #(
    .CLOCK_FREQ (CLK_HZ),
    .BAUD_RATE  (uart_tx_pkg::BR_115200),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .send       (send_if),
    .serial_out (serial_out),
    .tx_ready   (tx_ready),
    .tx_busy    (tx_busy)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int hs_count = 0;
  int push_timeouts = 0;
  int stall_cycles = 0;

  // Present a byte at a falling edge and hold it until it is accepted.
  task automatic push_byte(input logic [7:0] b);
    int w = 0;
    send_if.valid = 1'b1;
    send_if.data  = b;
    while (!send_if.ready && w < 2000) begin
      @(negedge clk);
      w++;
      stall_cycles++;
    end
    if (!send_if.ready) begin
      push_timeouts++;
    end else begin
      @(posedge clk);
      hs_count++;
      @(negedge clk);
    end
  endtask

  // Wait for a start bit, then sample every cycle of an 80-cycle frame against 'exp'.
  task automatic rx_frame(input logic [7:0] exp, input int max_wait,
                          output logic [7:0] got, output int waited, output int errs);
    logic eb;
    waited = 0;
    errs   = 0;
    got    = '0;
    do begin
      @(negedge clk);
      waited++;
    end while (serial_out !== 1'b0 && waited < max_wait);
    if (serial_out !== 1'b0) begin
      errs = FRAME;
      return;
    end
    for (int k = 0; k < FRAME; k++) begin
      if (k > 0) @(negedge clk);
      if (k < 8)       eb = 1'b0;
      else if (k < 72) eb = exp[(k-8)/8];
      else             eb = 1'b1;
      if (serial_out !== eb) errs++;
      if (k >= 8 && k < 72 && ((k - 8) % 8) == 4) got[(k-8)/8] = serial_out;
    end
  endtask

  task automatic test_reset();
    int bad = 0;
    send_if.valid = 1'b0;
    send_if.data  = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (serial_out !== 1'b1) begin n_bad++; $display("FAIL reset_line: got %b expected 1", serial_out); end
    n_cmp++; if (send_if.ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b expected 1", send_if.ready); end
    n_cmp++; if (tx_ready !== 1'b1) begin n_bad++; $display("FAIL reset_tx_ready: got %b expected 1", tx_ready); end
    n_cmp++; if (tx_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b expected 0", tx_busy); end
    rst_n = 1'b1;
    repeat (200) begin
      @(negedge clk);
      if (serial_out !== 1'b1 || send_if.ready !== 1'b1 || tx_busy !== 1'b0) bad++;
    end
    n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL reset_idle_200: got %0d bad cycles expected 0", bad); end
  endtask

  task automatic test_single_byte();
    logic [7:0] got;
    int waited, errs;
    int hs0 = hs_count;
    push_byte(8'hA5);
    send_if.valid = 1'b0;
    n_cmp++; if (serial_out !== 1'b1) begin n_bad++; $display("FAIL single_no_early_start: got %b expected 1", serial_out); end
    rx_frame(8'hA5, 4, got, waited, errs);
    n_cmp++; if (waited < 1 || waited > 2) begin n_bad++; $display("FAIL single_start_latency: got %0d expected 1..2", waited); end
    n_cmp++; if (errs !== 0) begin n_bad++; $display("FAIL single_frame_shape: got %0d bad cycles expected 0", errs); end
    n_cmp++; if (got !== 8'hA5) begin n_bad++; $display("FAIL single_data: got %h expected a5", got); end
    n_cmp++; if (tx_busy !== 1'b1) begin n_bad++; $display("FAIL single_busy_in_stop: got %b expected 1", tx_busy); end
    @(negedge clk);
    n_cmp++; if (tx_busy !== 1'b0) begin n_bad++; $display("FAIL single_busy_after: got %b expected 0", tx_busy); end
    n_cmp++; if (serial_out !== 1'b1) begin n_bad++; $display("FAIL single_line_idle: got %b expected 1", serial_out); end
    n_cmp++; if (hs_count - hs0 !== 1) begin n_bad++; $display("FAIL single_handshakes: got %0d expected 1", hs_count - hs0); end
  endtask

  task automatic test_burst();
    logic [7:0] got [6];
    int waits [6];
    int errs [6];
    logic ready_full, busy_full;
    int gaps = 0;
    int hs0 = hs_count;
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          push_byte(8'(i));
          if (i == 4) begin
            ready_full = send_if.ready;
            busy_full  = tx_busy;
          end
        end
        send_if.valid = 1'b0;
      end
      begin
        for (int j = 0; j < 6; j++) rx_frame(8'(j), (j == 0) ? 4 : 1, got[j], waits[j], errs[j]);
      end
    join
    n_cmp++; if (ready_full !== 1'b0) begin n_bad++; $display("FAIL burst_ready_when_full: got %b expected 0", ready_full); end
    n_cmp++; if (busy_full !== 1'b1) begin n_bad++; $display("FAIL burst_busy_when_full: got %b expected 1", busy_full); end
    for (int i = 0; i < 6; i++) begin
      n_cmp++;
      if (errs[i] !== 0 || got[i] !== 8'(i)) begin
        n_bad++;
        $display("FAIL burst_frame_%0d: got %h (%0d bad cycles) expected %h", i, got[i], errs[i], 8'(i));
      end
    end
    for (int i = 1; i < 6; i++) if (waits[i] !== 1) gaps++;
    n_cmp++; if (gaps !== 0) begin n_bad++; $display("FAIL burst_contiguous: got %0d gapped frames expected 0", gaps); end
    @(negedge clk);
    n_cmp++; if (tx_busy !== 1'b0 || send_if.ready !== 1'b1) begin
      n_bad++; $display("FAIL burst_drained: got busy=%b ready=%b expected busy=0 ready=1", tx_busy, send_if.ready);
    end
    n_cmp++; if (hs_count - hs0 !== 6) begin n_bad++; $display("FAIL burst_handshakes: got %0d expected 6", hs_count - hs0); end
  endtask

  task automatic test_backpressure();
    logic [7:0] vec [9];
    logic [7:0] got [9];
    int waits [9];
    int errs [9];
    int wrong = 0;
    int idle_bad = 0;
    int hs0 = hs_count;
    int st0 = stall_cycles;
    vec = '{8'h3A, 8'hC5, 8'h7E, 8'h81, 8'h10, 8'hEF, 8'h5A, 8'h96, 8'h01};
    fork
      begin
        for (int i = 0; i < 9; i++) push_byte(vec[i]);
        send_if.valid = 1'b0;
      end
      begin
        for (int j = 0; j < 9; j++) rx_frame(vec[j], (j == 0) ? 4 : 1, got[j], waits[j], errs[j]);
      end
    join
    for (int i = 0; i < 9; i++) if (errs[i] !== 0 || got[i] !== vec[i]) wrong++;
    n_cmp++; if (wrong !== 0) begin n_bad++; $display("FAIL bp_frames: got %0d wrong frames expected 0", wrong); end
    n_cmp++; if (stall_cycles - st0 <= 0) begin n_bad++; $display("FAIL bp_stalled: got %0d stall cycles expected >0", stall_cycles - st0); end
    n_cmp++; if (hs_count - hs0 !== 9) begin n_bad++; $display("FAIL bp_handshakes: got %0d expected 9", hs_count - hs0); end
    repeat (100) begin
      @(negedge clk);
      if (serial_out !== 1'b1 || tx_busy !== 1'b0) idle_bad++;
    end
    n_cmp++; if (idle_bad !== 0) begin n_bad++; $display("FAIL bp_no_duplicate: got %0d non-idle cycles expected 0", idle_bad); end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] got;
    int waited, errs;
    int w = 0;
    int idle_bad = 0;
    logic busy_before;
    fork
      begin
        push_byte(8'hFF);
        push_byte(8'h11);
        push_byte(8'h22);
        send_if.valid = 1'b0;
      end
      begin
        do begin @(negedge clk); w++; end while (serial_out !== 1'b0 && w < 10);
        repeat (36) @(negedge clk);
      end
    join
    n_cmp++; if (w >= 10) begin n_bad++; $display("FAIL midrst_start_seen: got timeout expected start bit"); end
    busy_before = tx_busy;
    n_cmp++; if (busy_before !== 1'b1) begin n_bad++; $display("FAIL midrst_busy_before: got %b expected 1", busy_before); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (serial_out !== 1'b1 || tx_busy !== 1'b0 || send_if.ready !== 1'b1) begin
      n_bad++; $display("FAIL midrst_async: got line=%b busy=%b ready=%b expected 1 0 1", serial_out, tx_busy, send_if.ready);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (200) begin
      @(negedge clk);
      if (serial_out !== 1'b1 || tx_busy !== 1'b0) idle_bad++;
    end
    n_cmp++; if (idle_bad !== 0) begin n_bad++; $display("FAIL midrst_fifo_flushed: got %0d non-idle cycles expected 0", idle_bad); end
    push_byte(8'h3C);
    send_if.valid = 1'b0;
    rx_frame(8'h3C, 4, got, waited, errs);
    n_cmp++; if (errs !== 0 || got !== 8'h3C) begin
      n_bad++; $display("FAIL midrst_clean_frame: got %h (%0d bad cycles) expected 3c", got, errs);
    end
    @(negedge clk);
  endtask

  task automatic test_full_wrap();
    for (int r = 0; r < 3; r++) begin
      logic [7:0] got [DEPTH+1];
      int waits [DEPTH+1];
      int errs [DEPTH+1];
      logic ready_full, busy_full;
      int wrong = 0;
      fork
        begin
          for (int i = 0; i <= DEPTH; i++) begin
            push_byte(8'(8'h40 + r * 16 + i));
            if (i == DEPTH) begin
              ready_full = send_if.ready;
              busy_full  = tx_busy;
            end
          end
          send_if.valid = 1'b0;
        end
        begin
          for (int j = 0; j <= DEPTH; j++)
            rx_frame(8'(8'h40 + r * 16 + j), (j == 0) ? 4 : 1, got[j], waits[j], errs[j]);
        end
      join
      n_cmp++; if (ready_full !== 1'b0 || busy_full !== 1'b1) begin
        n_bad++; $display("FAIL wrap_full_r%0d: got ready=%b busy=%b expected 0 1", r, ready_full, busy_full);
      end
      for (int i = 0; i <= DEPTH; i++)
        if (errs[i] !== 0 || got[i] !== 8'(8'h40 + r * 16 + i) || (i > 0 && waits[i] !== 1)) wrong++;
      n_cmp++; if (wrong !== 0) begin n_bad++; $display("FAIL wrap_frames_r%0d: got %0d wrong frames expected 0", r, wrong); end
      @(negedge clk);
      n_cmp++; if (send_if.ready !== 1'b1 || tx_busy !== 1'b0) begin
        n_bad++; $display("FAIL wrap_empty_r%0d: got ready=%b busy=%b expected 1 0", r, send_if.ready, tx_busy);
      end
    end
    n_cmp++; if (push_timeouts !== 0) begin n_bad++; $display("FAIL push_timeouts: got %0d expected 0", push_timeouts); end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_burst();
    test_backpressure();
    test_reset_mid_frame();
    test_full_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
